// File: rtl/instr_fetch_unit.sv
// Instruction-issue stage feeding the AND/ADD/FETCH pipe.
// Holds a loadable instruction memory, a program counter and a run-control FSM.
// A FETCH that reads a location written by either of the two previously issued
// instructions is held back with bubbles, because the downstream pipe has no forwarding.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   load_en/addr/data   memory write port, honoured outside RUN
//   start               single-cycle pulse, runs the program from address 0
//   instr, instr_valid  registered issue word and its real-instruction flag
//   pc                  address of the next word to be examined
//   busy, done, stall   RUN state, DONE state, hazard bubble being issued
module instr_fetch_unit #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter logic [7:0]  HALT_OP = 8'hFF,
    parameter logic [31:0] BUBBLE  = 32'h0300_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          start,
    output logic [31:0]   instr,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          stall
);

    localparam logic [7:0] OP_FETCH = 8'd2;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic          instr_valid_q, instr_valid_d;
    logic          stall_q, stall_d;
    logic          hist0_vld_q, hist0_vld_d;
    logic          hist1_vld_q, hist1_vld_d;
    logic [7:0]    hist0_dst_q, hist0_dst_d;
    logic [7:0]    hist1_dst_q, hist1_dst_d;
    // Word at address 0 captured at the start edge, so a load to address 0 in the
    // same cycle as start does not change the first instruction executed.
    logic          first_q, first_d;
    logic [31:0]   first_word_q, first_word_d;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   word;
    logic          hazard;
    logic          unused_bits;

    assign unused_bits = ^word[15:8];

    always_ff @(posedge clk) begin
        if (load_en && (state_q != StRun)) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        word   = first_q ? first_word_q : mem[pc_q];
        hazard = (word[31:24] == OP_FETCH) &&
                 ((hist0_vld_q && (word[7:0] == hist0_dst_q)) ||
                  (hist1_vld_q && (word[7:0] == hist1_dst_q)));
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = BUBBLE;
        instr_valid_d = 1'b0;
        stall_d       = 1'b0;
        hist0_vld_d   = hist0_vld_q;
        hist0_dst_d   = hist0_dst_q;
        hist1_vld_d   = hist1_vld_q;
        hist1_dst_d   = hist1_dst_q;
        first_d       = 1'b0;
        first_word_d  = first_word_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d      = StRun;
                    pc_d         = '0;
                    hist0_vld_d  = 1'b0;
                    hist1_vld_d  = 1'b0;
                    first_d      = 1'b1;
                    first_word_d = mem[0];
                end
            end
            StRun: begin
                // History shifts every RUN cycle; bubbles enter as invalid entries.
                hist1_vld_d = hist0_vld_q;
                hist1_dst_d = hist0_dst_q;
                hist0_vld_d = 1'b0;
                if (word[31:24] == HALT_OP) begin
                    state_d = StDone;
                end else if (hazard) begin
                    stall_d = 1'b1;
                end else begin
                    instr_d       = word;
                    instr_valid_d = 1'b1;
                    hist0_vld_d   = 1'b1;
                    hist0_dst_d   = word[23:16];
                    pc_d          = pc_q + AW'(1);  // wraps to 0 after the last word
                    if (pc_q == AW'(DEPTH - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            pc_q          <= '0;
            instr_q       <= BUBBLE;
            instr_valid_q <= 1'b0;
            stall_q       <= 1'b0;
            hist0_vld_q   <= 1'b0;
            hist0_dst_q   <= '0;
            hist1_vld_q   <= 1'b0;
            hist1_dst_q   <= '0;
            first_q       <= 1'b0;
            first_word_q  <= BUBBLE;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            stall_q       <= stall_d;
            hist0_vld_q   <= hist0_vld_d;
            hist0_dst_q   <= hist0_dst_d;
            hist1_vld_q   <= hist1_vld_d;
            hist1_dst_q   <= hist1_dst_d;
            first_q       <= first_d;
            first_word_q  <= first_word_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign stall       = stall_q;
    assign pc          = pc_q;
    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: expected issue words are queued per
// program and compared against instr/instr_valid/stall each cycle.
module tb_instr_fetch_unit;

    localparam logic [31:0] BUBBLE = 32'h0300_0000;
    localparam logic [31:0] HALT   = 32'hFF00_0000;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic [31:0] instr;
    logic        instr_valid;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    // {instr, valid, stall}
    logic [33:0] exp_q[$];

    instr_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic v, input logic s);
        exp_q.push_back({w, v, s});
    endtask

    task automatic load_word(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Pulses start, then compares one queued entry per cycle. poke_at pulses
    // start + a load to address 3 during RUN after that sample (-1: none).
    task automatic run_prog(input string tag, input logic [3:0] exp_pc, input int poke_at,
                            input logic ld_with_start, input logic [31:0] ld_word);
        int n;
        int last;
        logic [33:0] e;
        @(negedge clk);
        start = 1'b1;
        if (ld_with_start) begin
            load_en   = 1'b1;
            load_addr = 4'd0;
            load_data = ld_word;
        end
        @(negedge clk);
        start   = 1'b0;
        load_en = 1'b0;
        n    = 0;
        last = exp_q.size() - 1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_eq($sformatf("%s issue[%0d]", tag, n), {30'd0, instr, instr_valid, stall},
                     {30'd0, e});
            check_eq($sformatf("%s busy[%0d]", tag, n), {63'd0, busy}, {63'd0, n < last});
            if (n == poke_at) begin
                start     = 1'b1;
                load_en   = 1'b1;
                load_addr = 4'd3;
                load_data = HALT;
            end else begin
                start   = 1'b0;
                load_en = 1'b0;
            end
            n++;
        end
        start   = 1'b0;
        load_en = 1'b0;
        check_eq({tag, " done"}, {63'd0, done}, 64'd1);
        check_eq({tag, " pc"}, {60'd0, pc}, {60'd0, exp_pc});
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        #1;
        check_eq("reset instr", {32'd0, instr}, {32'd0, BUBBLE});
        check_eq("reset valid/busy/done/stall", {60'd0, instr_valid, busy, done, stall}, 64'd0);
        check_eq("reset pc", {60'd0, pc}, 64'd0);
        #12 rst = 1'b0;

        // Straight-line program
        load_word(4'd0, 32'h0105_0302);
        load_word(4'd1, 32'h0006_0F0A);
        load_word(4'd2, HALT);
        push(32'h0105_0302, 1'b1, 1'b0);
        push(32'h0006_0F0A, 1'b1, 1'b0);
        push(BUBBLE, 1'b0, 1'b0);
        run_prog("straight", 4'd2, -1, 1'b0, 32'd0);

        // Hazard at distance 1: two bubbles
        load_word(4'd0, 32'h0104_0102);
        load_word(4'd1, 32'h0207_0004);
        load_word(4'd2, HALT);
        push(32'h0104_0102, 1'b1, 1'b0);
        push(BUBBLE, 1'b0, 1'b1);
        push(BUBBLE, 1'b0, 1'b1);
        push(32'h0207_0004, 1'b1, 1'b0);
        push(BUBBLE, 1'b0, 1'b0);
        run_prog("dist1", 4'd2, -1, 1'b0, 32'd0);

        // Restart from DONE: history (dest 07 in hist1) must be cleared
        load_word(4'd0, 32'h0208_0007);
        load_word(4'd1, HALT);
        push(32'h0208_0007, 1'b1, 1'b0);
        push(BUBBLE, 1'b0, 1'b0);
        run_prog("restart", 4'd1, -1, 1'b0, 32'd0);

        // Load to address 0 together with start: old word runs first
        push(32'h0208_0007, 1'b1, 1'b0);
        push(BUBBLE, 1'b0, 1'b0);
        run_prog("ldstart", 4'd1, -1, 1'b1, 32'h01AA_0000);
        push(32'h01AA_0000, 1'b1, 1'b0);
        push(BUBBLE, 1'b0, 1'b0);
        run_prog("ldstart2", 4'd1, -1, 1'b0, 32'd0);

        // Hazard at distance 2: one bubble
        load_word(4'd0, 32'h0104_0102);
        load_word(4'd1, 32'h0005_0101);
        load_word(4'd2, 32'h0207_0004);
        load_word(4'd3, HALT);
        push(32'h0104_0102, 1'b1, 1'b0);
        push(32'h0005_0101, 1'b1, 1'b0);
        push(BUBBLE, 1'b0, 1'b1);
        push(32'h0207_0004, 1'b1, 1'b0);
        push(BUBBLE, 1'b0, 1'b0);
        run_prog("dist2", 4'd3, -1, 1'b0, 32'd0);

        // Same program, non-matching source: no bubble
        load_word(4'd2, 32'h0207_0009);
        push(32'h0104_0102, 1'b1, 1'b0);
        push(32'h0005_0101, 1'b1, 1'b0);
        push(32'h0207_0009, 1'b1, 1'b0);
        push(BUBBLE, 1'b0, 1'b0);
        run_prog("nohaz", 4'd3, -1, 1'b0, 32'd0);

        // Full memory, no HALT; start and load pulsed mid-run must be ignored
        for (int i = 0; i < 16; i++) begin
            load_word(4'(i), 32'h0100_0000 | (32'(i) << 16) | 32'(i));
        end
        for (int i = 0; i < 16; i++) begin
            push(32'h0100_0000 | (32'(i) << 16) | 32'(i), 1'b1, 1'b0);
        end
        run_prog("full", 4'd0, 5, 1'b0, 32'd0);
        for (int i = 0; i < 16; i++) begin
            push(32'h0100_0000 | (32'(i) << 16) | 32'(i), 1'b1, 1'b0);
        end
        run_prog("rerun", 4'd0, -1, 1'b0, 32'd0);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst instr", {32'd0, instr}, {32'd0, BUBBLE});
        check_eq("midrst valid/busy/done/stall", {60'd0, instr_valid, busy, done, stall}, 64'd0);
        check_eq("midrst pc", {60'd0, pc}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("postrst idle", {31'd0, instr, instr_valid, busy},
                 {31'd0, BUBBLE, 1'b0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
